uart_tx: RTL and testbench

UART transmitter: serializes one parallel word per request onto a single line as start bit, NB_DATA data bits LSB first, an optional parity bit, then stop bits. Bit timing comes from the shared 16x-oversampling baud tick that also drives the UART receiver. It sits between the host-side word interface and the TX pin, and is the counterpart of the UART receiver in the same design.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, oversampling ratio, parity modes.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // One-hot frame states shared by transmitter and receiver
  localparam logic [4:0] IDLE  = 5'b00001;
  localparam logic [4:0] START = 5'b00010;
  localparam logic [4:0] DATA  = 5'b00100;
  localparam logic [4:0] PAR   = 5'b01000;
  localparam logic [4:0] STOP  = 5'b10000;

  // Ceiling log2, used to size counters at elaboration
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res = res + 1;
    return res;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, optional parity,
// NB_STOP ticks of stop, all timed by a shared 16x baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_STOP = 16,
  parameter int unsigned PARITY  = 0
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_tx_done
);

  localparam int unsigned TICK_W = clog2(max2(OVERSAMPLE, NB_STOP));
  localparam int unsigned BIT_W  = clog2(NB_DATA);

  logic [4:0]         state, state_nxt;
  logic [TICK_W-1:0]  tick_cnt, tick_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_nxt;
  logic [NB_DATA-1:0] shift_reg, shift_nxt;
  logic               par_bit, par_nxt;
  logic               tx_nxt, busy_nxt, done_nxt;
  logic               last_os, last_stop, last_bit;

  assign last_os   = (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign last_stop = (tick_cnt == TICK_W'(NB_STOP - 1));
  assign last_bit  = (bit_cnt == BIT_W'(NB_DATA - 1));

  // State and datapath registers; reset drives the line idle-high at once
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      par_bit   <= par_nxt;
      o_tx      <= tx_nxt;
      o_busy    <= busy_nxt;
      o_tx_done <= done_nxt;
    end
  end

  // Next-state, counters and registered-output values
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    par_nxt   = par_bit;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        // A tick coinciding with the accept is deliberately not counted
        if (i_tx_start) begin
          state_nxt = START;
          shift_nxt = i_data;
          tick_nxt  = '0;
          par_nxt   = (PARITY == PAR_ODD) ? ~^i_data : ^i_data;
        end
      end
      START: begin
        if (i_tick) begin
          if (last_os) begin
            state_nxt = DATA;
            tick_nxt  = '0;
            bit_nxt   = '0;
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (last_os) begin
            shift_nxt = shift_reg >> 1;
            tick_nxt  = '0;
            if (last_bit) begin
              state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
            end else begin
              bit_nxt = bit_cnt + BIT_W'(1);
            end
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end
      PAR: begin
        if (i_tick) begin
          if (last_os) begin
            state_nxt = STOP;
            tick_nxt  = '0;
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (last_stop) begin
            state_nxt = IDLE;
            tick_nxt  = '0;
            done_nxt  = 1'b1;
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tick_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase

    // Line level is a function of the state being entered
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PAR:     tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations driven in parallel, each checked
// against a per-tick expected line sequence built from the frame format.
module tb_uart_tx;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic [7:0] data;
  logic [3:0] tx_w, busy_w, done_w;

  int checks   = 0;
  int failures = 0;
  int gap      = 0;
  int pos [NI];
  int len [NI];
  int acc [NI];
  bit exp_b [NI][256];

  always #5 clk = ~clk;

  uart_tx #(.NB_DATA(8), .NB_STOP(16), .PARITY(0)) u0 (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_start(start), .i_data(data),
    .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_tx_done(done_w[0]));
  uart_tx #(.NB_DATA(8), .NB_STOP(16), .PARITY(1)) u1 (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_start(start), .i_data(data),
    .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_tx_done(done_w[1]));
  uart_tx #(.NB_DATA(8), .NB_STOP(16), .PARITY(2)) u2 (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_start(start), .i_data(data),
    .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_tx_done(done_w[2]));
  uart_tx #(.NB_DATA(8), .NB_STOP(32), .PARITY(0)) u3 (
    .clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_start(start), .i_data(data),
    .o_tx(tx_w[3]), .o_busy(busy_w[3]), .o_tx_done(done_w[3]));

  function automatic int par_of(input int k);
    return (k == 1) ? 1 : (k == 2) ? 2 : 0;
  endfunction

  function automatic int stop_of(input int k);
    return (k == 3) ? 32 : 16;
  endfunction

  task automatic chk(input string tag, input int k, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s inst=%0d t=%0t got=%b exp=%b", tag, k, $time, obs, expv);
    end
  endtask

  task automatic push(input int k, input bit v, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_b[k][len[k]] = v;
      len[k]++;
    end
  endtask

  // Expected line level for every tick of one frame
  task automatic build(input int k, input logic [7:0] w);
    bit p;
    len[k] = 0;
    push(k, 1'b0, 16);
    for (int b = 0; b < 8; b++) push(k, w[b], 16);
    if (par_of(k) != 0) begin
      p = ($countones(w) % 2) == 1;
      if (par_of(k) == 2) p = ~p;
      push(k, p, 16);
    end
    push(k, 1'b1, stop_of(k));
  endtask

  // Compare outputs registered on the last edge, then model the coming edge
  task automatic sample();
    for (int k = 0; k < NI; k++) begin
      if (pos[k] >= 0) begin
        chk("busy_frame", k, busy_w[k], 1'b1);
        chk("done_early", k, done_w[k], 1'b0);
        chk("tx_bit", k, tx_w[k], exp_b[k][pos[k]]);
        if (tick) begin
          pos[k]++;
          if (pos[k] == len[k]) pos[k] = -3;
        end
      end else begin
        if (pos[k] == -3) begin
          chk("done_pulse", k, done_w[k], 1'b1);
          pos[k] = -1;
        end else begin
          chk("done_idle", k, done_w[k], 1'b0);
        end
        chk("busy_idle", k, busy_w[k], 1'b0);
        chk("tx_idle", k, tx_w[k], 1'b1);
        if (start && !rst) begin
          build(k, data);
          pos[k] = 0;
          acc[k]++;
        end
      end
    end
  endtask

  task automatic step();
    if (gap == 0) begin
      tick = 1'b1;
      gap  = int'($urandom_range(2, 0));
    end else begin
      tick = 1'b0;
      gap--;
    end
    sample();
  endtask

  task automatic cyc(input logic st, input logic [7:0] d);
    @(negedge clk);
    start = st;
    data  = d;
    step();
  endtask

  function automatic bit any_busy();
    for (int k = 0; k < NI; k++) if (pos[k] != -1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (any_busy() && n < budget) begin
      cyc(1'b0, 8'($urandom));
      n++;
    end
    chk("drain_timeout", 0, logic'(any_busy()), 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] w);
    cyc(1'b1, w);
    drain(4000);
    idle(8);
  endtask

  initial begin
    int n;
    int base;
    bit all_two;
    rst = 1'b1; tick = 1'b0; start = 1'b0; data = 8'h00;
    for (int k = 0; k < NI; k++) begin
      pos[k] = -1; len[k] = 0; acc[k] = 0;
    end

    // Reset state
    repeat (3) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    idle(5);

    // Basic frames across parity and stop-length variants
    send(8'h55);
    send(8'hA3);
    send(8'hFF);

    // Start request during DATA is ignored
    cyc(1'b1, 8'h34);
    n = 0;
    while (pos[0] >= 0 && pos[0] < 40 && n < 2000) begin
      cyc(1'b0, 8'h34);
      n++;
    end
    cyc(1'b1, 8'h12);
    drain(4000);
    idle(50);

    // Back-to-back frames with start held and data swapped at done
    base = acc[0];
    cyc(1'b1, 8'h0F);
    n = 0;
    all_two = 1'b0;
    while (!all_two && n < 4000) begin
      @(negedge clk);
      start = 1'b1;
      if (done_w[0]) data = 8'hF0;
      step();
      n++;
      all_two = 1'b1;
      for (int k = 0; k < NI; k++) if (acc[k] < base + 2) all_two = 1'b0;
    end
    chk("b2b_timeout", 0, logic'(all_two), 1'b1);
    drain(4000);
    idle(8);

    // Reset during data bit 3
    cyc(1'b1, 8'h5A);
    n = 0;
    while (pos[0] >= 0 && pos[0] < 16 * 4 + 5 && n < 2000) begin
      cyc(1'b0, 8'h5A);
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_tx", k, tx_w[k], 1'b1);
      chk("rst_busy", k, busy_w[k], 1'b0);
      chk("rst_done", k, done_w[k], 1'b0);
      pos[k] = -1;
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    idle(40);
    send(8'hC3);

    // Random words with random idle gaps
    for (int r = 0; r < 6; r++) begin
      idle(int'($urandom_range(6, 0)));
      send(8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
